// File: rtl/vga_plot_arbiter.sv
// Arbitrates the vga_adapter write port between NUM_REQ single-pixel requesters
// (round-robin) and a non-preemptible rectangle-fill engine.
`timescale 1ns/1ps
module vga_plot_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int X_MAX   = 159,
    parameter int Y_MAX   = 119
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_x,
    input  logic [7*NUM_REQ-1:0]   req_y,
    input  logic [3*NUM_REQ-1:0]   req_colour,
    output logic [NUM_REQ-1:0]     gnt,
    input  logic                   fill_start,
    input  logic [7:0]             fill_x0,
    input  logic [7:0]             fill_x1,
    input  logic [6:0]             fill_y0,
    input  logic [6:0]             fill_y1,
    input  logic [2:0]             fill_colour,
    output logic                   fill_busy,
    output logic                   fill_done,
    output logic [7:0]             x_out,
    output logic [6:0]             y_out,
    output logic [2:0]             colour,
    output logic                   plot
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {IDLE = 1'b0, FILL = 1'b1} state_t;

    state_t               state_r, state_s;
    logic [IW-1:0]        rr_r, rr_s, win_s;
    logic                 pend_r, pend_s, busy_r, busy_s, done_r, done_s, plot_r, plot_s;
    logic [NUM_REQ-1:0]   gnt_r, gnt_s;
    logic [7:0]           x_r, x_s, fx0_r, fx0_s, fx1_r, fx1_s, cx_r, cx_s;
    logic [6:0]           y_r, y_s, fy0_r, fy0_s, fy1_r, fy1_s, cy_r, cy_s;
    logic [2:0]           col_r, col_s, fcol_r, fcol_s;
    logic [7:0]           x1c_s, pix_x_s, nx_s, sel_x_s;
    logic [6:0]           y1c_s, pix_y_s, ny_s, sel_y_s;
    logic [2:0]           sel_c_s;
    logic                 empty_s, last_s, any_s;

    // Clip the requested rectangle to the screen and flag an empty result
    always_comb begin
        x1c_s   = (fill_x1 > 8'(X_MAX)) ? 8'(X_MAX) : fill_x1;
        y1c_s   = (fill_y1 > 7'(Y_MAX)) ? 7'(Y_MAX) : fill_y1;
        empty_s = (fill_x0 > x1c_s) || (fill_y0 > y1c_s);
    end

    // Round-robin search starting at the pointer, then mux out the winner's fields
    always_comb begin
        logic [IW-1:0] idx_v;
        any_s   = 1'b0;
        win_s   = '0;
        idx_v   = '0;
        sel_x_s = 8'd0;
        sel_y_s = 7'd0;
        sel_c_s = 3'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_v = IW'((int'(rr_r) + k) % NUM_REQ);
            if (!any_s && req[idx_v]) begin
                any_s = 1'b1;
                win_s = idx_v;
            end else begin
                win_s = win_s;
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (win_s == IW'(j)) begin
                sel_x_s = req_x[8*j +: 8];
                sel_y_s = req_y[7*j +: 7];
                sel_c_s = req_colour[3*j +: 3];
            end else begin
                sel_x_s = sel_x_s;
            end
        end
    end

    // Current fill pixel (first pixel comes straight from the latched origin) and its successor
    always_comb begin
        if (state_r == IDLE) begin
            pix_x_s = fx0_r;
            pix_y_s = fy0_r;
        end else begin
            pix_x_s = cx_r;
            pix_y_s = cy_r;
        end
        last_s = (pix_x_s == fx1_r) && (pix_y_s == fy1_r);
        if (pix_x_s == fx1_r) begin
            nx_s = fx0_r;
            ny_s = pix_y_s + 7'd1;
        end else begin
            nx_s = pix_x_s + 8'd1;
            ny_s = pix_y_s;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_s = state_r;
        rr_s    = rr_r;
        pend_s  = pend_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        plot_s  = 1'b0;
        gnt_s   = '0;
        x_s     = x_r;
        y_s     = y_r;
        col_s   = col_r;
        fx0_s   = fx0_r;
        fx1_s   = fx1_r;
        fy0_s   = fy0_r;
        fy1_s   = fy1_r;
        fcol_s  = fcol_r;
        cx_s    = cx_r;
        cy_s    = cy_r;

        if (fill_start && !busy_r) begin
            fx0_s  = fill_x0;
            fx1_s  = x1c_s;
            fy0_s  = fill_y0;
            fy1_s  = y1c_s;
            fcol_s = fill_colour;
            if (empty_s) begin
                done_s = 1'b1;
            end else begin
                pend_s = 1'b1;
                busy_s = 1'b1;
            end
        end else begin
            fcol_s = fcol_r;
        end

        case (state_r)
            IDLE: begin
                if (pend_r) begin
                    state_s = FILL;
                    plot_s  = 1'b1;
                    x_s     = pix_x_s;
                    y_s     = pix_y_s;
                    col_s   = fcol_r;
                    done_s  = last_s;
                    cx_s    = nx_s;
                    cy_s    = ny_s;
                end else if (any_s) begin
                    gnt_s[win_s] = 1'b1;
                    plot_s = (sel_x_s <= 8'(X_MAX)) && (sel_y_s <= 7'(Y_MAX));
                    x_s    = sel_x_s;
                    y_s    = sel_y_s;
                    col_s  = sel_c_s;
                    rr_s   = (int'(win_s) == NUM_REQ - 1) ? '0 : win_s + IW'(1);
                end else begin
                    plot_s = 1'b0;
                end
            end
            FILL: begin
                // done_r means the last pixel is on the port this cycle
                if (done_r) begin
                    state_s = IDLE;
                    busy_s  = 1'b0;
                    pend_s  = 1'b0;
                end else begin
                    plot_s = 1'b1;
                    x_s    = pix_x_s;
                    y_s    = pix_y_s;
                    col_s  = fcol_r;
                    done_s = last_s;
                    cx_s   = nx_s;
                    cy_s   = ny_s;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            rr_r    <= '0;
            pend_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            plot_r  <= 1'b0;
            gnt_r   <= '0;
            x_r     <= 8'd0;
            y_r     <= 7'd0;
            col_r   <= 3'd0;
            fx0_r   <= 8'd0;
            fx1_r   <= 8'd0;
            fy0_r   <= 7'd0;
            fy1_r   <= 7'd0;
            fcol_r  <= 3'd0;
            cx_r    <= 8'd0;
            cy_r    <= 7'd0;
        end else begin
            state_r <= state_s;
            rr_r    <= rr_s;
            pend_r  <= pend_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            plot_r  <= plot_s;
            gnt_r   <= gnt_s;
            x_r     <= x_s;
            y_r     <= y_s;
            col_r   <= col_s;
            fx0_r   <= fx0_s;
            fx1_r   <= fx1_s;
            fy0_r   <= fy0_s;
            fy1_r   <= fy1_s;
            fcol_r  <= fcol_s;
            cx_r    <= cx_s;
            cy_r    <= cy_s;
        end
    end

    assign gnt       = gnt_r;
    assign plot      = plot_r;
    assign x_out     = x_r;
    assign y_out     = y_r;
    assign colour    = col_r;
    assign fill_busy = busy_r;
    assign fill_done = done_r;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Scoreboard bench for vga_plot_arbiter: expected port values are queued as stimulus
// is driven and checked one record per clock, 1 ns after the rising edge.
`timescale 1ns/1ps
module tb_vga_plot_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_x;
    logic [27:0] req_y;
    logic [11:0] req_colour;
    logic [3:0]  gnt;
    logic        fill_start;
    logic [7:0]  fill_x0, fill_x1;
    logic [6:0]  fill_y0, fill_y1;
    logic [2:0]  fill_colour;
    logic        fill_busy, fill_done;
    logic [7:0]  x_out;
    logic [6:0]  y_out;
    logic [2:0]  colour;
    logic        plot;

    always #5 clk = ~clk;

    vga_plot_arbiter #(.NUM_REQ(4), .X_MAX(159), .Y_MAX(119)) dut (
        .clk(clk), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
        .req_colour(req_colour), .gnt(gnt), .fill_start(fill_start),
        .fill_x0(fill_x0), .fill_x1(fill_x1), .fill_y0(fill_y0), .fill_y1(fill_y1),
        .fill_colour(fill_colour), .fill_busy(fill_busy), .fill_done(fill_done),
        .x_out(x_out), .y_out(y_out), .colour(colour), .plot(plot)
    );

    typedef struct {
        logic [3:0] gnt;
        logic       plot;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] col;
        logic       busy;
        logic       done;
        logic       chk_pos;
        string      name;
    } exp_t;

    typedef struct {
        logic [3:0] req;
        logic [7:0] x3;
        logic [6:0] y3;
        logic [3:0] egnt;
        logic       eplot;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[12];
    int   n_cmp = 0;
    int   n_err = 0;
    logic [7:0] hx;
    logic [6:0] hy;
    logic [2:0] hc;

    task automatic push(input string nm, input logic [3:0] g, input logic p, input logic [7:0] x,
                        input logic [6:0] y, input logic [2:0] c, input logic b, input logic d,
                        input logic chk);
        exp_t e;
        e.gnt = g; e.plot = p; e.x = x; e.y = y; e.col = c;
        e.busy = b; e.done = d; e.chk_pos = chk; e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic push_pix(input string nm, input logic [3:0] g, input logic [7:0] x,
                            input logic [6:0] y, input logic [2:0] c, input logic b, input logic d);
        hx = x; hy = y; hc = c;
        push(nm, g, 1'b1, x, y, c, b, d, 1'b1);
    endtask

    task automatic push_idle(input string nm, input logic b, input logic d);
        push(nm, 4'b0000, 1'b0, hx, hy, hc, b, d, 1'b1);
    endtask

    task automatic push_fill(input string nm, input int x0, input int x1, input int y0,
                             input int y1, input logic [2:0] c, input int limit);
        int n;
        int total;
        n = 0;
        total = (x1 - x0 + 1) * (y1 - y0 + 1);
        for (int yy = y0; yy <= y1; yy++) begin
            for (int xx = x0; xx <= x1; xx++) begin
                n++;
                if (n <= limit) push_pix(nm, 4'b0000, 8'(xx), 7'(yy), c, 1'b1, n == total);
            end
        end
    endtask

    task automatic start_fill(input logic [7:0] x0, input logic [6:0] y0, input logic [7:0] x1,
                              input logic [6:0] y1, input logic [2:0] c);
        fill_x0 = x0; fill_y0 = y0; fill_x1 = x1; fill_y1 = y1; fill_colour = c;
        fill_start = 1'b1;
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        fill_start = 1'b0;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: DUT cycle with no expectation queued");
        end else begin
            e = exp_q.pop_front();
            if (gnt !== e.gnt || plot !== e.plot || fill_busy !== e.busy || fill_done !== e.done ||
                (e.chk_pos && (x_out !== e.x || y_out !== e.y || colour !== e.col))) begin
                n_err++;
                $display("FAIL %s @%0t: got gnt=%b plot=%b x=%0d y=%0d colour=%b busy=%b done=%b, want gnt=%b plot=%b x=%0d y=%0d colour=%b busy=%b done=%b",
                         e.name, $time, gnt, plot, x_out, y_out, colour, fill_busy, fill_done,
                         e.gnt, e.plot, e.x, e.y, e.col, e.busy, e.done);
            end
        end
    endtask

    task automatic drain();
        while (exp_q.size() != 0) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int total;
        logic [7:0] ex;
        logic [6:0] ey;
        logic [2:0] ec;

        reset = 1'b1; req = 4'b0000; fill_start = 1'b0;
        fill_x0 = 8'd0; fill_x1 = 8'd0; fill_y0 = 7'd0; fill_y1 = 7'd0; fill_colour = 3'd0;
        for (int i = 0; i < 4; i++) begin
            req_x[8*i +: 8]      = 8'(20 + i);
            req_y[7*i +: 7]      = 7'(10 + i);
            req_colour[3*i +: 3] = 3'(i + 1);
        end

        // reset held two cycles
        hx = 8'd0; hy = 7'd0; hc = 3'd0;
        push_idle("reset_c1", 1'b0, 1'b0);
        push_idle("reset_c2", 1'b0, 1'b0);
        drain();
        reset = 1'b0;

        // all four requesting continuously: rotation with no idle cycle
        req = 4'b1111;
        push_pix("rr_all_0", 4'b0001, 8'd20, 7'd10, 3'd1, 1'b0, 1'b0);
        push_pix("rr_all_1", 4'b0010, 8'd21, 7'd11, 3'd2, 1'b0, 1'b0);
        push_pix("rr_all_2", 4'b0100, 8'd22, 7'd12, 3'd3, 1'b0, 1'b0);
        push_pix("rr_all_3", 4'b1000, 8'd23, 7'd13, 3'd4, 1'b0, 1'b0);
        push_pix("rr_all_4", 4'b0001, 8'd20, 7'd10, 3'd1, 1'b0, 1'b0);
        drain();

        // single requester 1 at (80,60,001), then dropped
        req = 4'b0010;
        req_x[15:8] = 8'd80; req_y[13:7] = 7'd60; req_colour[5:3] = 3'b001;
        push_pix("single_req1", 4'b0010, 8'd80, 7'd60, 3'b001, 1'b0, 1'b0);
        tick();
        req = 4'b0000;
        push_idle("single_drop", 1'b0, 1'b0);
        tick();
        req_x[15:8] = 8'd21; req_y[13:7] = 7'd11; req_colour[5:3] = 3'd2;

        // round-robin vectors; pointer is 2 here
        vecs[0]  = '{4'b0001, 8'd23,  7'd13,  4'b0001, 1'b1};
        vecs[1]  = '{4'b0101, 8'd23,  7'd13,  4'b0100, 1'b1};
        vecs[2]  = '{4'b0011, 8'd23,  7'd13,  4'b0001, 1'b1};
        vecs[3]  = '{4'b0000, 8'd23,  7'd13,  4'b0000, 1'b0};
        vecs[4]  = '{4'b1001, 8'd23,  7'd13,  4'b1000, 1'b1};
        vecs[5]  = '{4'b1010, 8'd23,  7'd13,  4'b0010, 1'b1};
        vecs[6]  = '{4'b1010, 8'd23,  7'd13,  4'b1000, 1'b1};
        vecs[7]  = '{4'b1000, 8'd200, 7'd13,  4'b1000, 1'b0};
        vecs[8]  = '{4'b0110, 8'd23,  7'd13,  4'b0010, 1'b1};
        vecs[9]  = '{4'b0110, 8'd23,  7'd13,  4'b0100, 1'b1};
        vecs[10] = '{4'b1000, 8'd23,  7'd120, 4'b1000, 1'b0};
        vecs[11] = '{4'b0001, 8'd23,  7'd13,  4'b0001, 1'b1};
        for (int v = 0; v < 12; v++) begin
            req = vecs[v].req;
            req_x[31:24] = vecs[v].x3;
            req_y[27:21] = vecs[v].y3;
            w = 0;
            for (int j = 0; j < 4; j++) if (vecs[v].egnt[j]) w = j;
            ex = (w == 3) ? vecs[v].x3 : 8'(20 + w);
            ey = (w == 3) ? vecs[v].y3 : 7'(10 + w);
            ec = 3'(w + 1);
            if (vecs[v].egnt == 4'b0000) push_idle($sformatf("vec%0d_idle", v), 1'b0, 1'b0);
            else if (vecs[v].eplot) push_pix($sformatf("vec%0d", v), vecs[v].egnt, ex, ey, ec, 1'b0, 1'b0);
            else push($sformatf("vec%0d_offscreen", v), vecs[v].egnt, 1'b0, ex, ey, ec, 1'b0, 1'b0, 1'b0);
            tick();
        end
        req = 4'b0000;
        req_x[31:24] = 8'd23; req_y[27:21] = 7'd13;

        // 65x65 fill; requester 0 raised mid-fill waits for the fill to end
        start_fill(8'd48, 7'd28, 8'd112, 7'd92, 3'b111);
        push_idle("fill_pending", 1'b1, 1'b0);
        push_fill("fill_big", 48, 112, 28, 92, 3'b111, 100000);
        push_idle("fill_big_end", 1'b0, 1'b0);
        push_pix("grant_after_fill", 4'b0001, 8'd20, 7'd10, 3'd1, 1'b0, 1'b0);
        total = exp_q.size();
        for (int k = 0; k < total; k++) begin
            if (k == 100) req = 4'b0001;
            tick();
        end
        req = 4'b0000;
        push_idle("grant_after_fill_drop", 1'b0, 1'b0);
        tick();

        // clipped fill ends at (159,119); inverted rect finishes with no plot
        start_fill(8'd150, 7'd110, 8'd200, 7'd127, 3'b010);
        push_idle("clip_pending", 1'b1, 1'b0);
        push_fill("fill_clip", 150, 159, 110, 119, 3'b010, 100000);
        push_idle("clip_end", 1'b0, 1'b0);
        drain();
        start_fill(8'd60, 7'd60, 8'd50, 7'd70, 3'b101);
        push_idle("empty_done", 1'b0, 1'b1);
        push_idle("empty_after", 1'b0, 1'b0);
        drain();

        // reset at pixel 500 of the big fill aborts it without fill_done
        start_fill(8'd48, 7'd28, 8'd112, 7'd92, 3'b111);
        push_idle("abort_pending", 1'b1, 1'b0);
        push_fill("fill_abort", 48, 112, 28, 92, 3'b111, 500);
        drain();
        reset = 1'b1;
        hx = 8'd0; hy = 7'd0; hc = 3'd0;
        push_idle("abort_reset_c1", 1'b0, 1'b0);
        push_idle("abort_reset_c2", 1'b0, 1'b0);
        drain();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) push_idle("abort_quiet", 1'b0, 1'b0);
        drain();
        start_fill(8'd48, 7'd28, 8'd50, 7'd29, 3'b110);
        push_idle("restart_pending", 1'b1, 1'b0);
        push_fill("fill_restart", 48, 50, 28, 29, 3'b110, 100000);
        push_idle("restart_end", 1'b0, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
